num_conv_ctrl: RTL

//  Sequencer for the number-system display path. It synchronises the two push-buttons
//  (translate, clear) and runs an iterative double-dabble (one shift/add-3 step per clk) on a

---
 rtl/num_conv_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/num_conv_ctrl.sv
// rtl/num_conv_ctrl.sv - button-driven binary-to-BCD display sequencer
// Iterative double-dabble, one shift per clk, with atomic latch of hex/BCD/overflow.
module num_conv_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int MAX_DISP = 99
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_trans_n,
  input  logic                  key_clr_n,
  input  logic [WIDTH-1:0]      switches,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      hex_out,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic          trans_s1_q, trans_s2_q, trans_evt_q;
  logic          clr_s1_q, clr_s2_q, clr_evt_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, cap_q, cap_d, hex_q, hex_d;
  logic [AW-1:0] acc_q, acc_d, acc_adj, bcd_q, bcd_d;
  logic          done_q, done_d, ovf_q, ovf_d;

  // Events are one-cycle pulses on the synchronised falling edge of each button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trans_s1_q  <= 1'b1;
      trans_s2_q  <= 1'b1;
      trans_evt_q <= 1'b0;
      clr_s1_q    <= 1'b1;
      clr_s2_q    <= 1'b1;
      clr_evt_q   <= 1'b0;
    end else begin
      trans_s1_q  <= key_trans_n;
      trans_s2_q  <= trans_s1_q;
      trans_evt_q <= ~trans_s1_q & trans_s2_q;
      clr_s1_q    <= key_clr_n;
      clr_s2_q    <= clr_s1_q;
      clr_evt_q   <= ~clr_s1_q & clr_s2_q;
    end
  end

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    acc_d   = acc_q;
    cap_d   = cap_q;
    hex_d   = hex_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trans_evt_q) begin
          cap_d   = switches;
          sh_d    = switches;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        {acc_d, sh_d} = {acc_adj[AW-2:0], sh_q, 1'b0};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        hex_d   = cap_q;
        bcd_d   = acc_q;
        ovf_d   = 32'(cap_q) > 32'(MAX_DISP);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Clear outranks everything, including a translate arriving in the same cycle.
    if (clr_evt_q) begin
      state_d = IDLE;
      done_d  = 1'b0;
      hex_d   = '0;
      bcd_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      acc_q   <= '0;
      cap_q   <= '0;
      hex_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      hex_q   <= hex_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign hex_out = hex_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;
endmodule
